alu_arbiter: RTL and testbench

- Shares one 8-bit ALU (opcodes: add, increment, and, or, xor, not, shift right, shift left) between two requesters.
- Arbitrates between the two and registers the operands.
- Runs the operation for 1 to 2^CNT_W iterations, feeding each result back into operand A. This gives multi-bit shifts and repeated add or increment.
- Returns the final result plus flags on a one-cycle response pulse, tagged with the requester ID.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu.sv | 54 +++++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - OP_* : 3-bit ALU opcode encodings
//   - state_e : arbiter FSM states (IDLE, EXEC, RESP)
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared ALU arbiter.
//   master : requester side (drives req_*, observes req_ready, resp_*, busy)
//   slave  : arbiter side
// Signals:
//   req_valid[1:0], req_ready[1:0]    per-requester handshake
//   reqN_opcode/a/b/count             per-requester operation
//   resp_valid, resp_id               one-cycle result pulse and owner
//   resp_result, resp_cout, resp_ov, resp_sign, resp_zero
//   busy                              arbiter executing or responding
interface alu_arbiter_if #(
    parameter int unsigned CNT_W = 3
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req0_opcode;
    logic [2:0]       req1_opcode;
    logic [7:0]       req0_a;
    logic [7:0]       req1_a;
    logic [7:0]       req0_b;
    logic [7:0]       req1_b;
    logic [CNT_W-1:0] req0_count;
    logic [CNT_W-1:0] req1_count;
    logic             resp_valid;
    logic             resp_id;
    logic [7:0]       resp_result;
    logic             resp_cout;
    logic             resp_ov;
    logic             resp_sign;
    logic             resp_zero;
    logic             busy;

    modport master (
        output req_valid, req0_opcode, req1_opcode, req0_a, req1_a,
               req0_b, req1_b, req0_count, req1_count,
        input  req_ready, resp_valid, resp_id, resp_result, resp_cout,
               resp_ov, resp_sign, resp_zero, busy
    );

    modport slave (
        input  req_valid, req0_opcode, req1_opcode, req0_a, req1_a,
               req0_b, req1_b, req0_count, req1_count,
        output req_ready, resp_valid, resp_id, resp_result, resp_cout,
               resp_ov, resp_sign, resp_zero, busy
    );

endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU.
//   op   in  3  opcode (alu_pkg::OP_*)
//   a, b in  8  operands
//   y    out 8  result (mod 256)
//   cout out 1  carry out: add/inc carry, shr bit 0 of a, shl bit 7 of a, else 0
//   ov   out 1  signed overflow of add/inc, else 0
module alu
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       cout,
    output logic       ov
);

    logic [8:0] sum;

    always_comb begin
        y    = 8'h00;
        cout = 1'b0;
        ov   = 1'b0;
        sum  = 9'h000;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b};
                y    = sum[7:0];
                cout = sum[8];
                ov   = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            OP_INC: begin
                sum  = {1'b0, a} + 9'd1;
                y    = sum[7:0];
                cout = sum[8];
                ov   = (a == 8'h7f);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHR: begin
                y    = {1'b0, a[7:1]};
                cout = a[0];
            end
            OP_SHL: begin
                y    = {a[6:0], 1'b0};
                cout = a[7];
            end
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters. A granted request is latched,
// run count+1 times with the result fed back into operand A, and returned on a
// one-cycle resp_valid pulse tagged with the requester id.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  alu_arbiter_if.slave (request handshake, response, busy)
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins contention;
//                          undefined: round-robin on last_grant.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic [7:0]       acc_q;
    logic [7:0]       b_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_q;
    logic             last_grant_q;
    logic             ov_acc_q;

    logic             resp_valid_q;
    logic             resp_id_q;
    logic [7:0]       resp_result_q;
    logic             resp_cout_q;
    logic             resp_ov_q;
    logic             resp_sign_q;
    logic             resp_zero_q;

    logic             grant;
    logic             accept;
    logic [7:0]       alu_y;
    logic             alu_cout;
    logic             alu_ov;

    alu u_alu (
        .op   (op_q),
        .a    (acc_q),
        .b    (b_q),
        .y    (alu_y),
        .cout (alu_cout),
        .ov   (alu_ov)
    );

    // Grant selection; only meaningful while some req_valid bit is set.
    always_comb begin
        grant = 1'b0;
        unique case (bus.req_valid)
            2'b01: grant = 1'b0;
            2'b10: grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11: grant = 1'b0;
`else
            2'b11: grant = ~last_grant_q;
`endif
            default: grant = 1'b0;
        endcase
    end

    assign accept = (state_q == IDLE) && (bus.req_valid != 2'b00);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= 8'h00;
            b_q           <= 8'h00;
            op_q          <= 3'b000;
            cnt_q         <= '0;
            id_q          <= 1'b0;
            last_grant_q  <= 1'b1;
            ov_acc_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= 8'h00;
            resp_cout_q   <= 1'b0;
            resp_ov_q     <= 1'b0;
            resp_sign_q   <= 1'b0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q        <= grant ? bus.req1_a : bus.req0_a;
                        b_q          <= grant ? bus.req1_b : bus.req0_b;
                        op_q         <= grant ? bus.req1_opcode : bus.req0_opcode;
                        cnt_q        <= grant ? bus.req1_count : bus.req0_count;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        ov_acc_q     <= 1'b0;
                    end
                end
                EXEC: begin
                    acc_q    <= alu_y;
                    ov_acc_q <= ov_acc_q | alu_ov;
                    if (cnt_q == '0) begin
                        // Final iteration: capture the response so it is valid
                        // throughout RESP and holds afterwards.
                        resp_valid_q  <= 1'b1;
                        resp_id_q     <= id_q;
                        resp_result_q <= alu_y;
                        resp_cout_q   <= alu_cout;
                        resp_ov_q     <= ov_acc_q | alu_ov;
                        resp_sign_q   <= alu_y[7];
                        resp_zero_q   <= (alu_y == 8'h00);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_cout   = resp_cout_q;
    assign bus.resp_ov     = resp_ov_q;
    assign bus.resp_sign   = resp_sign_q;
    assign bus.resp_zero   = resp_zero_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a driver issues requests and pushes
// expected responses from a behavioural model; a monitor compares.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [2:0]       op;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [CNT_W-1:0] cnt;
    } req_t;

    typedef struct {
        logic       id;
        logic [7:0] result;
        logic       cout;
        logic       ov;
        logic       sign;
        logic       zero;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.CNT_W(CNT_W)) bus ();

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Shared with the monitor: expectations for the current cycle.
    logic [1:0] exp_ready = 2'b00;
    logic       exp_busy  = 1'b0;
    bit         chk_en    = 1'b0;
    bit         done      = 1'b0;

    // Reference model state.
    int   busy_left = 0;
    logic tb_last   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic id, input req_t r, input int c);
        exp_t e;
        int   acc, addend, s, sa, sd;
        bit   cout, ov;
        acc  = int'(r.a);
        cout = 1'b0;
        ov   = 1'b0;
        for (int i = 0; i <= int'(r.cnt); i++) begin
            case (r.op)
                OP_ADD, OP_INC: begin
                    addend = (r.op == OP_INC) ? 1 : int'(r.b);
                    s      = acc + addend;
                    cout   = (s > 255);
                    sa     = (acc > 127) ? acc - 256 : acc;
                    sd     = (addend > 127) ? addend - 256 : addend;
                    ov     = ov | ((sa + sd) > 127) | ((sa + sd) < -128);
                    acc    = s % 256;
                end
                OP_AND: begin acc = acc & int'(r.b); cout = 1'b0; end
                OP_OR:  begin acc = acc | int'(r.b); cout = 1'b0; end
                OP_XOR: begin acc = acc ^ int'(r.b); cout = 1'b0; end
                OP_NOT: begin acc = 255 - acc; cout = 1'b0; end
                OP_SHR: begin cout = (acc % 2) == 1; acc = acc / 2; end
                default: begin cout = (acc > 127); acc = (acc * 2) % 256; end
            endcase
        end
        e.id     = id;
        e.result = 8'(acc);
        e.cout   = cout;
        e.ov     = ov;
        e.sign   = (acc > 127);
        e.zero   = (acc == 0);
        e.cyc    = c + int'(r.cnt) + 2;
        return e;
    endfunction

    function automatic logic grant_of(input logic [1:0] v);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return !tb_last;
`endif
    endfunction

    function automatic req_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input int cnt);
        req_t r;
        r.op  = op;
        r.a   = a;
        r.b   = b;
        r.cnt = CNT_W'(cnt);
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.op  = 3'($urandom_range(0, 7));
        r.a   = 8'($urandom);
        r.b   = 8'($urandom);
        r.cnt = CNT_W'($urandom);
        return r;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input logic [1:0] v, input req_t r0, input req_t r1, input bit do_rst,
                        output bit acc);
        logic g;
        #1;
        rst             = do_rst;
        bus.req_valid   = v;
        bus.req0_opcode = r0.op;
        bus.req0_a      = r0.a;
        bus.req0_b      = r0.b;
        bus.req0_count  = r0.cnt;
        bus.req1_opcode = r1.op;
        bus.req1_a      = r1.a;
        bus.req1_b      = r1.b;
        bus.req1_count  = r1.cnt;
        #1;
        acc = 1'b0;
        if (do_rst) begin
            chk_en = 1'b0;
        end else begin
            g         = grant_of(v);
            exp_busy  = (busy_left != 0);
            exp_ready = (busy_left == 0 && v != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk_en    = 1'b1;
            if (busy_left == 0 && v != 2'b00) begin
                sb.push_back(model(g, g ? r1 : r0, cyc));
                tb_last = g;
                acc     = 1'b1;
                busy_left = int'(g ? r1.cnt : r0.cnt) + 3;
            end
        end
        @(negedge clk);
        if (do_rst) begin
            busy_left = 0;
            tb_last   = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(2'b00, '0, '0, 1'b0, a);
    endtask

    // Holds the request until the model says it is accepted.
    task automatic issue(input logic [1:0] v, input req_t r0, input req_t r1);
        bit a;
        a = 1'b0;
        while (!a) step(v, r0, r1, 1'b0, a);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t        e;
        logic [12:0] hold;
        bit          hold_ok;
        bit          prev_rst;
        hold     = '0;
        hold_ok  = 1'b0;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (prev_rst) begin
                hold    = '0;
                hold_ok = 1'b1;
            end
            if (chk_en) begin
                chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                chk("busy", 32'(bus.busy), 32'(exp_busy));
            end
            if (bus.resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_result", 32'(bus.resp_result), 32'(e.result));
                    chk("resp_cout", 32'(bus.resp_cout), 32'(e.cout));
                    chk("resp_ov", 32'(bus.resp_ov), 32'(e.ov));
                    chk("resp_sign", 32'(bus.resp_sign), 32'(e.sign));
                    chk("resp_zero", 32'(bus.resp_zero), 32'(e.zero));
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    hold = {e.id, e.result, e.cout, e.ov, e.sign, e.zero};
                end
            end else if (hold_ok) begin
                chk("resp_valid", 32'(bus.resp_valid), 32'(0));
                chk("resp_hold", 32'({bus.resp_id, bus.resp_result, bus.resp_cout, bus.resp_ov,
                                      bus.resp_sign, bus.resp_zero}), 32'(hold));
            end
            if (rst) sb.delete();
            prev_rst = rst;
            if (done) begin
                chk("scoreboard_empty", 32'(sb.size()), 32'(0));
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    // Driver.
    initial begin
        bit a;
        bus.req_valid   = 2'b00;
        bus.req0_opcode = '0;
        bus.req0_a      = '0;
        bus.req0_b      = '0;
        bus.req0_count  = '0;
        bus.req1_opcode = '0;
        bus.req1_a      = '0;
        bus.req1_b      = '0;
        bus.req1_count  = '0;
        @(negedge clk);
        step(2'b00, '0, '0, 1'b1, a);
        step(2'b00, '0, '0, 1'b1, a);
        idle(2);

        issue(2'b01, mk(OP_ADD, 8'h7f, 8'h01, 0), '0);
        issue(2'b10, '0, mk(OP_SHL, 8'h01, 8'h00, 3));
        issue(2'b01, mk(OP_INC, 8'hff, 8'h00, 0), '0);
        for (int i = 0; i < 4; i++)
            issue(2'b11, mk(OP_XOR, 8'h5a, 8'(i), i), mk(OP_SHR, 8'h80, 8'h00, i));

        // Reset on the third EXEC cycle discards the operation.
        idle(4);
        issue(2'b01, mk(OP_ADD, 8'h10, 8'h10, 7), '0);
        idle(2);
        step(2'b00, '0, '0, 1'b1, a);
        issue(2'b11, mk(OP_OR, 8'h0f, 8'hf0, 1), mk(OP_AND, 8'hff, 8'h3c, 2));

        issue(2'b10, '0, mk(OP_ADD, 8'h40, 8'h40, 1));
        issue(2'b01, mk(OP_NOT, 8'h00, 8'h00, 7), '0);

        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 2));
            issue(2'($urandom_range(1, 3)), rand_req(), rand_req());
        end

        while (busy_left > 0) idle(1);
        idle(2);
        done = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
